// File: rtl/nbc_host_if.sv
`timescale 1ns/1ps
// nbc_host_if
//   Host-side companion to the NBC classifier. Packs a 32-bit word stream into
//   the 784-bit test_vector, releases the NBC core from reset, waits for its
//   label (or a timeout) and offers the captured result on a valid/ready port.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  vector word stream; in_last marks the final word
//   test_vector                vector to the NBC core (bit 0 = MSB of word 0)
//   nbc_rstn                   registered active-low reset to the NBC core
//   test_label_valid/_out_label  label handshake from the NBC core
//   res_valid/res_ready        result handshake; res_label, res_timeout payload
//   frame_err                  sticky framing error, cleared only by rstn
//   busy                       high whenever not loading
//
// State table
//   state    | meaning
//   S_LOAD   | accepting stream words into test_vector, NBC held in reset
//   S_RUN    | NBC released, waiting for label or timeout
//   S_RESULT | result held on res_* until consumed, NBC back in reset
module nbc_host_if #(
  parameter int VEC_BITS  = 784,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 25,
  parameter int TIMEOUT   = 16383
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  output logic [0:VEC_BITS-1] test_vector,
  output logic                nbc_rstn,
  input  logic                test_label_valid,
  input  logic [3:0]          test_out_label,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [3:0]          res_label,
  output logic                res_timeout,
  output logic                frame_err,
  output logic                busy
);

  // Bits carried by the final, partially used word.
  localparam int LAST_BITS = VEC_BITS - (NUM_WORDS-1)*WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS+1);
  localparam int TMR_W     = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_RESULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [TMR_W-1:0] timer;
  logic             last_word;
  logic             accept;

  assign last_word = (word_cnt == CNT_W'(NUM_WORDS-1));
  assign accept    = in_valid & in_ready;
  assign busy      = (state != S_LOAD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_LOAD;
      word_cnt    <= '0;
      timer       <= '0;
      test_vector <= '0;
      nbc_rstn    <= 1'b0;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      res_label   <= 4'h0;
      res_timeout <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            // in_last must coincide exactly with the final word; otherwise
            // drop the word and restart framing from word 0.
            if (in_last != last_word) begin
              frame_err <= 1'b1;
              word_cnt  <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              for (int k = 0; k < NUM_WORDS-1; k++) begin
                if (word_cnt == CNT_W'(k))
                  test_vector[k*WORD_W +: WORD_W] <= in_data;
              end
              if (last_word) begin
                // Only the upper bits of the final word belong to the vector.
                test_vector[(NUM_WORDS-1)*WORD_W +: LAST_BITS] <= in_data[WORD_W-1 -: LAST_BITS];
                state    <= S_RUN;
                nbc_rstn <= 1'b1;
                timer    <= '0;
                in_ready <= 1'b0;
              end
            end
          end
        end

        S_RUN: begin
          timer <= timer + 1'b1;
          // A label arriving on the timeout cycle still counts as a real result.
          if (nbc_rstn && test_label_valid) begin
            res_label   <= test_out_label;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            nbc_rstn    <= 1'b0;
            state       <= S_RESULT;
          end else if (timer == TMR_W'(TIMEOUT-1)) begin
            res_label   <= 4'hF;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            nbc_rstn    <= 1'b0;
            state       <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            word_cnt  <= '0;
            in_ready  <= 1'b1;
            state     <= S_LOAD;
          end
        end

        default: begin
          state    <= S_LOAD;
          nbc_rstn <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbc_host_if.sv
`timescale 1ns/1ps
// Bench for nbc_host_if. Two instances share all inputs: u_a with the default
// timeout (always sees the mock label) and u_b with a 64-cycle timeout.
module tb_nbc_host_if;

  localparam int TOUT_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, in_last, tlv, res_ready;
  logic [31:0] in_data;
  logic [3:0]  tol;

  logic        in_ready_a, nbc_rstn_a, res_valid_a, res_timeout_a, frame_err_a, busy_a;
  logic [3:0]  res_label_a;
  logic [0:783] tv_a;
  logic        in_ready_b, nbc_rstn_b, res_valid_b, res_timeout_b, frame_err_b, busy_b;
  logic [3:0]  res_label_b;
  logic [0:783] tv_b;

  nbc_host_if u_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .test_vector(tv_a), .nbc_rstn(nbc_rstn_a),
    .test_label_valid(tlv), .test_out_label(tol), .res_valid(res_valid_a),
    .res_ready(res_ready), .res_label(res_label_a), .res_timeout(res_timeout_a),
    .frame_err(frame_err_a), .busy(busy_a)
  );

  nbc_host_if #(.TIMEOUT(TOUT_B)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .test_vector(tv_b), .nbc_rstn(nbc_rstn_b),
    .test_label_valid(tlv), .test_out_label(tol), .res_valid(res_valid_b),
    .res_ready(res_ready), .res_label(res_label_b), .res_timeout(res_timeout_b),
    .frame_err(frame_err_b), .busy(busy_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] w [25];
  logic        exp_ferr;

  typedef struct {
    int         err_pos;   // -1 clean, 0..23 early in_last, 24 missing in_last
    int         d;         // cycles after release before the mock label
    logic [3:0] lab;
    int         lat_b;     // expected release->res_valid cycles for u_b
    logic [3:0] lab_b;
    logic       to_b;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [0:783] exp_vec();
    logic [0:783] v;
    v = '0;
    for (int k = 0; k < 25; k++)
      for (int j = 0; j < 32; j++)
        if (32*k + j < 784) v[32*k + j] = w[k][31-j];
    return v;
  endfunction

  task automatic chk_vec(input string name, input logic [0:783] act);
    logic [0:783] e;
    int bad;
    e = exp_vec();
    bad = -1;
    for (int i = 783; i >= 0; i--) if (act[i] !== e[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s bit %0d actual=%b required=%b", name, bad, act[bad], e[bad]);
    end
  endtask

  // Reference timing for the short-timeout instance: label presented on the
  // (d+1)th edge of RUN wins unless the timeout edge (TOUT_B) comes first.
  task automatic model_b(input int d, input logic [3:0] lab,
                         output int lat, output logic [3:0] l, output logic to);
    if (d + 1 <= TOUT_B) begin lat = d + 1; l = lab;  to = 1'b0; end
    else                 begin lat = TOUT_B; l = 4'hF; to = 1'b1; end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic send_word(input logic [31:0] data, input logic last, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = data; in_last = last;
    t = 0;
    while (!in_ready_b && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("in_ready_wait", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
  endtask

  task automatic load_frame(input int err_pos, input int maxgap);
    if (err_pos >= 0) begin
      for (int k = 0; k <= err_pos; k++)
        send_word(w[k], (k == err_pos) && (err_pos < 24), $urandom_range(0, maxgap));
      exp_ferr = 1'b1;
      chk("ferr_set", 32'({frame_err_a, frame_err_b}), 32'b11);
      chk("err_no_release", 32'({nbc_rstn_a, nbc_rstn_b, busy_a, busy_b, in_ready_a, in_ready_b}), 32'b000011);
    end
    for (int k = 0; k < 25; k++) send_word(w[k], k == 24, $urandom_range(0, maxgap));
    chk("release", 32'({nbc_rstn_a, nbc_rstn_b, busy_a, busy_b, in_ready_a, in_ready_b}), 32'b111100);
    chk("ferr_hold", 32'({frame_err_a, frame_err_b}), 32'({exp_ferr, exp_ferr}));
    chk_vec("vec_a", tv_a);
    chk_vec("vec_b", tv_b);
  endtask

  task automatic run_case(input int d, input logic [3:0] lab, output int lat_a, output int lat_b);
    lat_a = -1; lat_b = -1;
    for (int n = 1; n <= 300 && (lat_a < 0 || lat_b < 0); n++) begin
      tlv = (n == d + 1);
      tol = (n == d + 1) ? lab : 4'($urandom);
      @(posedge clk); #1;
      if (lat_a < 0 && res_valid_a) lat_a = n;
      if (lat_b < 0 && res_valid_b) lat_b = n;
    end
    tlv = 1'b0;
  endtask

  task automatic check_result(input int d, input logic [3:0] lab, input int e_lat_b,
                              input logic [3:0] e_lab_b, input logic e_to_b);
    int la, lb;
    run_case(d, lab, la, lb);
    chk("lat_a", la, d + 1);
    chk("label_a", 32'(res_label_a), 32'(lab));
    chk("timeout_a", 32'(res_timeout_a), 32'd0);
    chk("lat_b", lb, e_lat_b);
    chk("label_b", 32'(res_label_b), 32'(e_lab_b));
    chk("timeout_b", 32'(res_timeout_b), 32'(e_to_b));
    chk("nbc_rstn_low", 32'({nbc_rstn_a, nbc_rstn_b, in_ready_a, in_ready_b}), 32'd0);
  endtask

  task automatic handshake(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", 32'({res_valid_a, res_valid_b, in_ready_a, in_ready_b}), 32'b1100);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("handshake", 32'({res_valid_a, res_valid_b, in_ready_a, in_ready_b, busy_a, busy_b}), 32'b001100);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int el; logic [3:0] ell; logic eto;
    int ep, d; logic [3:0] lab;

    tbl[0] = '{-1,  0, 4'd5,  1, 4'd5, 1'b0};
    tbl[1] = '{10, 20, 4'd2, 21, 4'd2, 1'b0};
    tbl[2] = '{24, 62, 4'd9, 63, 4'd9, 1'b0};
    tbl[3] = '{-1, 63, 4'd4, 64, 4'd4, 1'b0};   // label on the timeout edge wins
    tbl[4] = '{-1, 64, 4'd6, 64, 4'hF, 1'b1};   // one cycle late: timeout
    tbl[5] = '{ 0,  5, 4'hF,  6, 4'hF, 1'b0};   // in_last on the very first word

    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    tlv = 1'b0; tol = '0; res_ready = 1'b0; exp_ferr = 1'b0;

    #3;
    chk("rst_out_a", 32'({in_ready_a, nbc_rstn_a, res_valid_a, res_label_a, res_timeout_a, frame_err_a, busy_a}), 32'd0);
    chk("rst_out_b", 32'({in_ready_b, nbc_rstn_b, res_valid_b, res_label_b, res_timeout_b, frame_err_b, busy_b}), 32'd0);
    chk("rst_vec", 32'((|tv_a) | (|tv_b)), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'({in_ready_a, in_ready_b}), 32'b11);

    // res_ready without a pending result changes nothing.
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_ready_ignored", 32'({res_valid_a, busy_a, in_ready_a, res_valid_b, busy_b, in_ready_b}), 32'b001001);

    // Test 1: fixed pattern, mapping of first and last words.
    for (int k = 0; k < 25; k++) w[k] = 32'hA5A50000 | 32'(k);
    load_frame(-1, 0);
    chk("t1_head", tv_a[0:31], 32'hA5A50000);
    chk("t1_tail", 32'(tv_a[768:783]), 32'h0000A5A5);
    chk("t1_word1", tv_a[32:63], 32'hA5A50001);

    // Test 2: label 7 after 100 cycles (short-timeout instance gives up at 64).
    check_result(100, 4'd7, TOUT_B, 4'hF, 1'b1);

    // Test 3: result held under back-pressure.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t3_hold", 32'({res_valid_a, res_label_a, in_ready_a, res_timeout_a, busy_a}), 32'({1'b1, 4'd7, 1'b0, 1'b0, 1'b1}));
    end
    handshake(0);

    // Test 4: timeout on u_b, then a normal label 3.
    for (int k = 0; k < 25; k++) w[k] = $urandom;
    load_frame(-1, 1);
    check_result(70, 4'd3, TOUT_B, 4'hF, 1'b1);
    handshake(2);
    for (int k = 0; k < 25; k++) w[k] = $urandom;
    load_frame(-1, 0);
    check_result(10, 4'd3, 11, 4'd3, 1'b0);
    handshake(0);

    // Test 5: early in_last on word 10, then a clean frame.
    for (int k = 0; k < 25; k++) w[k] = $urandom;
    load_frame(10, 0);
    check_result(30, 4'd12, 31, 4'd12, 1'b0);
    handshake(1);
    chk("t5_ferr_sticky", 32'({frame_err_a, frame_err_b}), 32'b11);

    // Table-driven cases around the timeout boundary and framing errors.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 25; k++) w[k] = $urandom;
      load_frame(tbl[t].err_pos, 1);
      check_result(tbl[t].d, tbl[t].lab, tbl[t].lat_b, tbl[t].lab_b, tbl[t].to_b);
      handshake(t % 3);
    end

    // Randomized frames against the reference timing model.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 25; k++) w[k] = $urandom;
      ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
      d   = $urandom_range(0, 130);
      lab = 4'($urandom);
      model_b(d, lab, el, ell, eto);
      load_frame(ep, 2);
      check_result(d, lab, el, ell, eto);
      handshake($urandom_range(0, 3));
    end

    // Test 6: reset mid-RUN is immediate and drops the pending result.
    for (int k = 0; k < 25; k++) w[k] = $urandom;
    load_frame(-1, 0);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    chk("t6_async_a", 32'({in_ready_a, nbc_rstn_a, res_valid_a, res_label_a, res_timeout_a, frame_err_a, busy_a}), 32'd0);
    chk("t6_async_b", 32'({in_ready_b, nbc_rstn_b, res_valid_b, res_label_b, res_timeout_b, frame_err_b, busy_b}), 32'd0);
    chk("t6_vec", 32'((|tv_a) | (|tv_b)), 32'd0);
    exp_ferr = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    tlv = 1'b1; tol = 4'd5;
    @(posedge clk); #1;
    tlv = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("t6_no_result", 32'({res_valid_a, res_valid_b, busy_a, busy_b, nbc_rstn_a, nbc_rstn_b}), 32'd0);
    chk("t6_ferr_cleared", 32'({frame_err_a, frame_err_b}), 32'({exp_ferr, exp_ferr}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
